// File: rtl/receiver.sv
// 8N1 serial receiver that loads each good byte into sample memory at consecutive
// addresses from 0 and raises a finished flag after the LAST_ADDRESS write.
module receiver #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [15:0] LAST_ADDRESS = 16'hFFFF
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iRx,
    output logic [7:0]  oData,
    output logic [15:0] oAddress,
    output logic        oWriteEnable,
    output logic        oReceiveFinished,
    output logic        oFramingError
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic              rx_meta;
    logic              rx_s;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;

    // Both flops reset high so a reset never looks like a start bit.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= iRx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state            <= IDLE;
            baud_cnt         <= '0;
            bit_idx          <= '0;
            shift_reg        <= 8'h00;
            oData            <= 8'h00;
            oAddress         <= 16'h0000;
            oWriteEnable     <= 1'b0;
            oReceiveFinished <= 1'b0;
            oFramingError    <= 1'b0;
        end else begin
            oWriteEnable  <= 1'b0;
            oFramingError <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            oData        <= shift_reg;
                            oWriteEnable <= 1'b1;
                            state        <= WRITE;
                        end else begin
                            oFramingError <= 1'b1;
                            state         <= WAIT_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                // A held-low line (break) must return high before a new start bit counts.
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (oAddress == LAST_ADDRESS) begin
                        oReceiveFinished <= 1'b1;
                        state            <= DONE;
                    end else begin
                        oAddress <= oAddress + 16'd1;
                        state    <= IDLE;
                    end
                end
                DONE: begin
                    oReceiveFinished <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/receiver.md
# receiver

Serial-to-memory loader for the RS-232 link. It deserialises 8N1 frames arriving on the rx line and writes each good byte into sample memory at consecutive addresses starting from 0. When the byte for the last address has been written, it raises a finished flag. It is the inbound counterpart of the memory-to-tx sender: the host fills memory through this block, and the sender drains memory back to the host.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per bit (50 MHz / 115200 baud); must be ≥ 4.
- LAST_ADDRESS, default 16'hFFFF: address of the final byte; the write at this address completes the transfer.

- iClock  in  1  system clock; one clock domain, all logic on posedge.
- iReset  in  1  reset, asynchronous and active-high.
- iRx  in  1  serial line, idle high, asynchronous to iClock.
- oData  out  8  last received byte, stable while oWriteEnable is high.
- oAddress  out  16  write address for oData.
- oWriteEnable  out  1  one-cycle memory write strobe.
- oReceiveFinished  out  1  high once the LAST_ADDRESS byte is written; held high until reset.
- oFramingError  out  1  one-cycle pulse when a stop bit is sampled low.

## Operation
- iRx passes through a two-flop synchroniser; both flops reset to 1. All decisions use the synchronised value rx_s.
- A bit counter and a baud counter, width clog2(CLKS_PER_BIT), count from 0 to CLKS_PER_BIT-1.
- States and transitions:
  - IDLE: on rx_s = 0, go to START and clear the baud counter.
  - START: after CLKS_PER_BIT/2 (integer divide) cycles, sample rx_s.
    - If rx_s = 1, this was a glitch: go to IDLE with no output.
    - If rx_s = 0, go to DATA and clear the bit index.
  - DATA: every CLKS_PER_BIT cycles, sample one bit, LSB first, into a shift register. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If rx_s = 1, load oData and go to WRITE.
    - If rx_s = 0, pulse oFramingError, discard the byte, leave oAddress unchanged, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s = 1, then go to IDLE. This prevents a break condition from being read as back-to-back start bits.
  - WRITE: oWriteEnable = 1 for exactly one cycle.
    - If oAddress == LAST_ADDRESS, go to DONE with oAddress unchanged.
    - Otherwise increment oAddress and go to IDLE.
  - DONE: oReceiveFinished = 1. Ignore iRx; no further writes or error pulses. Only reset leaves this state.
- Undefined state encodings go to IDLE.
- oAddress never wraps; it saturates at LAST_ADDRESS via DONE.

## Timing
- Reset values:
  - State IDLE.
  - oData = 8'h00 and oAddress = 16'h0000.
  - oWriteEnable, oReceiveFinished and oFramingError = 0.
  - Shift register and counters = 0.
- Let t0 be the first cycle with rx_s = 0. This is 2 to 3 cycles after the iRx falling edge because of the synchroniser.
- Start sample: t0 + CLKS_PER_BIT/2.
- Data bit k (k = 0..7) sample: t0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Stop sample: t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- oWriteEnable is high in the cycle after the stop sample. The new oAddress value is visible one cycle later.
- oFramingError is high in the cycle after a bad stop sample.
- Back-to-back frames are supported: IDLE is re-entered at least CLKS_PER_BIT/2 − 2 cycles before the next start edge at nominal baud.
- Asynchronous reset mid-frame aborts immediately. The partial byte is lost, no write strobe is issued, and oAddress returns to 0.

## Test plan
- CLKS_PER_BIT = 16, send 0xA5 at the nominal rate → one oWriteEnable pulse with oData = 8'hA5 and oAddress = 0, then oAddress = 1; oFramingError stays 0.
- Send bytes 0x00, 0xFF, 0x3C back-to-back with no idle gap → writes to addresses 0, 1, 2 with those values, in order.
- Pulse iRx low for 4 cycles (CLKS_PER_BIT = 16) → no write and no error; state back in IDLE; oAddress unchanged.
- Send a frame with the stop bit low, then a valid 0x55 → oFramingError pulses once with no write; 0x55 is then written at the unchanged address (0).
- LAST_ADDRESS = 16'h0003, send 5 bytes → four writes at addresses 0..3; oReceiveFinished rises after the fourth write; the fifth byte produces no write; oAddress stays at 3.
- Assert iReset during data bit 4 of a frame, release it, then send 0x81 → no write from the aborted frame; 0x81 is written at address 0.
